// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: hazard sequencer
// state encoding and next-PC select codes.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle. Perf counter outputs exist
// only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [4:0] FD_rs;
    logic [4:0] FD_rt;
    logic       FD_uses_rt;
    logic       DX_MemRead;
    logic [4:0] DX_RD;
    logic       DX_jump;
    logic       XM_branch;
    logic       XM_MemRead;
    logic       XM_MemWrite;
    logic       dmem_ready;

    logic       pc_stall;
    logic       fd_stall;
    logic       dx_stall;
    logic       xm_stall;
    logic       fd_flush;
    logic       dx_bubble;
    logic       xm_flush;
    logic       mw_bubble;
    logic [1:0] pc_sel;
    logic       mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu;
    logic [CNT_W-1:0] perf_flush;
    logic [CNT_W-1:0] perf_memwait;
`endif

    modport master (
        output FD_rs, FD_rt, FD_uses_rt, DX_MemRead, DX_RD, DX_jump,
        output XM_branch, XM_MemRead, XM_MemWrite, dmem_ready,
        input  pc_stall, fd_stall, dx_stall, xm_stall,
        input  fd_flush, dx_bubble, xm_flush, mw_bubble,
        input  pc_sel, mem_err
`ifdef HAZARD_PERF_CNT_EN
        , input perf_lu, perf_flush, perf_memwait
`endif
    );

    modport slave (
        input  FD_rs, FD_rt, FD_uses_rt, DX_MemRead, DX_RD, DX_jump,
        input  XM_branch, XM_MemRead, XM_MemWrite, dmem_ready,
        output pc_stall, fd_stall, dx_stall, xm_stall,
        output fd_flush, dx_bubble, xm_flush, mw_bubble,
        output pc_sel, mem_err
`ifdef HAZARD_PERF_CNT_EN
        , output perf_lu, perf_flush, perf_memwait
`endif
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter for hazard statistics.
// Present only when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Hazard sequencer: load-use interlock, branch/jump squash, dmem freeze.
// Optional HAZARD_PERF_CNT_EN adds saturating perf counters.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 64
`ifdef HAZARD_PERF_CNT_EN
    , parameter int unsigned CNT_W         = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam logic [7:0] LU_LAST  = 8'(LU_STALL_CYCLES - 1);
    localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);
    localparam bit         LU_MULTI = (LU_STALL_CYCLES > 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       err_q, err_d;
    logic       mem_busy, lu_haz;

    assign mem_busy = (hz.XM_MemRead | hz.XM_MemWrite) & ~hz.dmem_ready;
    assign lu_haz   = hz.DX_MemRead & (hz.DX_RD != 5'd0) &
                      ((hz.DX_RD == hz.FD_rs) |
                       (hz.FD_uses_rt & (hz.DX_RD == hz.FD_rt)));
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign hz.mem_err = err_q;

    always_comb begin
        state_d      = ST_RUN;
        cnt_d        = 8'd0;
        err_d        = err_q;
        hz.pc_sel    = PC_SEL_SEQ;
        hz.pc_stall  = 1'b0;
        hz.fd_stall  = 1'b0;
        hz.dx_stall  = 1'b0;
        hz.xm_stall  = 1'b0;
        hz.fd_flush  = 1'b0;
        hz.dx_bubble = 1'b0;
        hz.xm_flush  = 1'b0;
        hz.mw_bubble = 1'b0;
        if (mem_busy) begin
            // Branch/jump stay parked in the frozen regs until release
            hz.pc_stall  = 1'b1;
            hz.fd_stall  = 1'b1;
            hz.dx_stall  = 1'b1;
            hz.xm_stall  = 1'b1;
            hz.mw_bubble = 1'b1;
            state_d      = ST_MEM_WAIT;
            cnt_d        = (state_q == ST_MEM_WAIT) ? cnt_inc : 8'd1;
            if (cnt_d >= TMO)
                err_d = 1'b1;
        end else if (hz.XM_branch) begin
            hz.pc_sel    = PC_SEL_BR;
            hz.fd_flush  = 1'b1;
            hz.dx_bubble = 1'b1;
            hz.xm_flush  = 1'b1;
        end else if (hz.DX_jump) begin
            hz.pc_sel    = PC_SEL_JMP;
            hz.fd_flush  = 1'b1;
            hz.dx_bubble = 1'b1;
        end else if ((state_q == ST_LU_STALL) || lu_haz) begin
            hz.pc_stall  = 1'b1;
            hz.fd_stall  = 1'b1;
            hz.dx_bubble = 1'b1;
            if (state_q == ST_LU_STALL) begin
                if (cnt_q < LU_LAST) begin
                    state_d = ST_LU_STALL;
                    cnt_d   = cnt_inc;
                end
            end else if (LU_MULTI) begin
                state_d = ST_LU_STALL;
                cnt_d   = 8'd1;
            end
        end
        if (rst) begin
            hz.pc_sel    = PC_SEL_SEQ;
            hz.pc_stall  = 1'b0;
            hz.fd_stall  = 1'b0;
            hz.dx_stall  = 1'b0;
            hz.xm_stall  = 1'b0;
            hz.fd_flush  = 1'b0;
            hz.dx_bubble = 1'b0;
            hz.xm_flush  = 1'b0;
            hz.mw_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // A dx bubble without an IF/ID flush can only be a load-use bubble
    hazard_perf_cnt #(.W(CNT_W)) u_perf_lu (
        .clk (clk),
        .rst (rst),
        .inc (hz.dx_bubble & ~hz.fd_flush),
        .cnt (hz.perf_lu)
    );
    hazard_perf_cnt #(.W(CNT_W)) u_perf_flush (
        .clk (clk),
        .rst (rst),
        .inc (hz.fd_flush),
        .cnt (hz.perf_flush)
    );
    hazard_perf_cnt #(.W(CNT_W)) u_perf_memwait (
        .clk (clk),
        .rst (rst),
        .inc (mem_busy),
        .cnt (hz.perf_memwait)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven in lockstep and
// checked each cycle against a bubble-budget model plus literal rows.
module tb_hazard_ctrl;

    localparam logic [10:0] O_NONE = 11'b00_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] O_LU   = 11'b00_1_1_0_0_0_1_0_0_0;
    localparam logic [10:0] O_BR   = 11'b01_0_0_0_0_1_1_1_0_0;
    localparam logic [10:0] O_JMP  = 11'b10_0_0_0_0_1_1_0_0_0;
    localparam logic [10:0] O_FRZ  = 11'b00_1_1_1_1_0_0_0_1_0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if hz1();
    hazard_ctrl_if hz3();

    hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(64)) dut1 (
        .clk (clk),
        .rst (rst),
        .hz  (hz1.slave)
    );

    hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .hz  (hz3.slave)
    );

    logic [10:0] o1, o3;
    assign o1 = {hz1.pc_sel, hz1.pc_stall, hz1.fd_stall, hz1.dx_stall,
                 hz1.xm_stall, hz1.fd_flush, hz1.dx_bubble, hz1.xm_flush,
                 hz1.mw_bubble, hz1.mem_err};
    assign o3 = {hz3.pc_sel, hz3.pc_stall, hz3.fd_stall, hz3.dx_stall,
                 hz3.xm_stall, hz3.fd_flush, hz3.dx_bubble, hz3.xm_flush,
                 hz3.mw_bubble, hz3.mem_err};

    int n_pass = 0;
    int n_tot  = 0;

    string       lit_tag;
    bit          lit_sel;
    logic [10:0] lit_val;

    // Model: remaining load-use bubbles, consecutive wait cycles, sticky error
    int lu_left [2] = '{0, 0};
    int wcnt    [2] = '{0, 0};
    bit err     [2] = '{0, 0};
    int lu_n    [2] = '{1, 3};
    int tmo     [2] = '{64, 4};

    always @(negedge clk) begin
        logic [10:0] e, a;
        logic busy, luh;
        busy = (hz1.XM_MemRead | hz1.XM_MemWrite) & ~hz1.dmem_ready;
        luh  = hz1.DX_MemRead && (hz1.DX_RD != 5'd0) &&
               ((hz1.DX_RD == hz1.FD_rs) ||
                (hz1.FD_uses_rt && (hz1.DX_RD == hz1.FD_rt)));
        for (int k = 0; k < 2; k++) begin
            e = O_NONE;
            if (rst) begin
                lu_left[k] = 0;
                wcnt[k]    = 0;
                err[k]     = 0;
            end else begin
                if (busy) begin
                    e = O_FRZ;
                    wcnt[k]++;
                    lu_left[k] = 0;
                end else begin
                    wcnt[k] = 0;
                    if (hz1.XM_branch) begin
                        e = O_BR;
                        lu_left[k] = 0;
                    end else if (hz1.DX_jump) begin
                        e = O_JMP;
                        lu_left[k] = 0;
                    end else if (lu_left[k] > 0) begin
                        e = O_LU;
                        lu_left[k]--;
                    end else if (luh) begin
                        e = O_LU;
                        lu_left[k] = lu_n[k] - 1;
                    end
                end
                e[0] = err[k];
                if (busy && (wcnt[k] >= tmo[k]))
                    err[k] = 1;
            end
            a = (k == 0) ? o1 : o3;
            n_tot++;
            if (a === e)
                n_pass++;
            else
                $display("FAIL model_dut%0d t=%0t actual=%b required=%b",
                         lu_n[k], $time, a, e);
        end
        a = lit_sel ? o3 : o1;
        n_tot++;
        if (a === lit_val)
            n_pass++;
        else
            $display("FAIL %s dut%0d actual=%b required=%b",
                     lit_tag, lit_sel ? 3 : 1, a, lit_val);
    end

    task automatic apply(
        input string      t,
        input bit         r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input bit         ur,
        input bit         dmr,
        input logic [4:0] rd,
        input bit         j,
        input bit         br,
        input bit         xmr,
        input bit         xmw,
        input bit         rdy,
        input bit         ls,
        input logic [10:0] lv
    );
        rst             = r;
        hz1.FD_rs       = rs;   hz3.FD_rs       = rs;
        hz1.FD_rt       = rt;   hz3.FD_rt       = rt;
        hz1.FD_uses_rt  = ur;   hz3.FD_uses_rt  = ur;
        hz1.DX_MemRead  = dmr;  hz3.DX_MemRead  = dmr;
        hz1.DX_RD       = rd;   hz3.DX_RD       = rd;
        hz1.DX_jump     = j;    hz3.DX_jump     = j;
        hz1.XM_branch   = br;   hz3.XM_branch   = br;
        hz1.XM_MemRead  = xmr;  hz3.XM_MemRead  = xmr;
        hz1.XM_MemWrite = xmw;  hz3.XM_MemWrite = xmw;
        hz1.dmem_ready  = rdy;  hz3.dmem_ready  = rdy;
        lit_tag = t;
        lit_sel = ls;
        lit_val = lv;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //     tag          r  rs rt ur dmr rd j br xr xw rdy sel expect
        apply("rst_br",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, O_NONE);
        apply("rst_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        apply("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_NONE);
        apply("lu1",        0, 2, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, O_LU);
        apply("lu1_done",   0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_NONE);
        apply("lu3_b3",     0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_LU);
        apply("lu3_end",    0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        apply("lu_rt",      0, 1, 5, 1, 1, 5, 0, 0, 0, 0, 1, 1, O_LU);
        apply("rt_b2",      0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, O_LU);
        apply("rt_b3",      0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, O_LU);
        apply("rt_end",     0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        apply("rt_unused",  0, 1, 5, 0, 1, 5, 0, 0, 0, 0, 1, 0, O_NONE);
        apply("rd_zero",    0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        apply("lu_c",       0, 7, 0, 0, 1, 7, 0, 0, 0, 0, 1, 1, O_LU);
        apply("br_in_lu",   0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, O_BR);
        apply("after_br",   0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        apply("frz1",       0, 3, 0, 0, 1, 3, 0, 1, 1, 0, 0, 0, O_FRZ);
        apply("frz2",       0, 3, 0, 0, 1, 3, 0, 1, 1, 0, 0, 0, O_FRZ);
        apply("frz3",       0, 3, 0, 0, 1, 3, 0, 1, 1, 0, 0, 0, O_FRZ);
        apply("frz4",       0, 3, 0, 0, 1, 3, 0, 1, 1, 0, 0, 1, O_FRZ);
        apply("rel_br",     0, 3, 0, 0, 1, 3, 0, 1, 1, 0, 1, 1, O_BR | 11'd1);
        apply("err_hold",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE | 11'd1);
        apply("rst_clr",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        apply("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        apply("jmp_lu",     0, 2, 0, 0, 1, 2, 1, 0, 0, 0, 1, 0, O_JMP);
        apply("after_jmp",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        apply("st_busy",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_FRZ);
        apply("st_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_NONE);
        apply("rdy_noop",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        apply("busy_lu",    0, 4, 0, 0, 1, 4, 0, 0, 1, 0, 0, 1, O_FRZ);
        apply("rel_lu",     0, 4, 0, 0, 1, 4, 0, 0, 1, 0, 1, 1, O_LU);
        apply("rel_lu_b2",  0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_LU);
        apply("rel_lu_b3",  0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_LU);
        apply("rel_lu_end", 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
